// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// and data access. Round-robin grant, one access in flight, registered memory
// port, one-cycle done pulse with read data, watchdog abort on a silent memory.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_done,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  owner
);

  // Counter just wide enough to hold TIMEOUT; one bit when the watchdog is off.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             owner_r;   // doubles as last_owner for round-robin
  logic             pick_data_s;
  logic             timeout_s;

  // Round-robin pick: on a conflict the side that did not own the last access wins.
  always_comb begin
    pick_data_s = 1'b0;
    if (d_req && if_req) begin
      pick_data_s = ~owner_r;
    end else if (d_req) begin
      pick_data_s = 1'b1;
    end else begin
      pick_data_s = 1'b0;
    end
  end

  // Watchdog expiry; a zero TIMEOUT never expires.
  always_comb begin
    timeout_s = 1'b0;
    if (TIMEOUT > 0) begin
      timeout_s = (cnt_r == TO_VAL);
    end else begin
      timeout_s = 1'b0;
    end
  end

  assign owner = owner_r;

  // Access sequencer: state, latched request, registered memory port and responses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      owner_r   <= 1'b0;
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
      rdata     <= '0;
      err       <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      // Pulses default low and are raised only on the cycle they belong to.
      if_gnt  <= 1'b0;
      d_gnt   <= 1'b0;
      if_done <= 1'b0;
      d_done  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (if_req || d_req) begin
            state_r   <= ACC;
            cnt_r     <= '0;
            owner_r   <= pick_data_s;
            mem_en    <= 1'b1;
            mem_we    <= pick_data_s ? d_we : 1'b0;
            mem_addr  <= pick_data_s ? d_addr : if_addr;
            mem_wdata <= pick_data_s ? d_wdata : '0;
            if_gnt    <= ~pick_data_s;
            d_gnt     <= pick_data_s;
          end else begin
            state_r <= IDLE;
          end
        end
        ACC: begin
          if (mem_ready) begin
            // A memory acknowledge beats a watchdog expiry in the same cycle.
            state_r <= RESP;
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            rdata   <= mem_we ? '0 : mem_rdata;
            err     <= 1'b0;
            if_done <= ~owner_r;
            d_done  <= owner_r;
          end else if (timeout_s) begin
            state_r <= RESP;
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            rdata   <= '0;
            err     <= 1'b1;
            if_done <= ~owner_r;
            d_done  <= owner_r;
          end else if (TIMEOUT > 0) begin
            cnt_r <= cnt_r + CNT_W'(1);
          end else begin
            cnt_r <= cnt_r;
          end
        end
        RESP: begin
          // Requests are not looked at here; a held request is re-sampled in IDLE.
          state_r <= IDLE;
          err     <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
          err     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table of single accesses,
// scoreboard of expected responses, and hand-written conflict, watchdog and
// mid-access reset sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we, mem_ready;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic        if_gnt, if_done, d_gnt, d_done, err, mem_en, mem_we, owner;
  logic [31:0] rdata, mem_addr, mem_wdata;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic        is_data;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    int          waits;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        owner;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  logic exp_owner_q[$];
  vec_t vecs[5];

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .rdata(rdata), .err(err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One complete access from IDLE; called at a falling edge, returns at one.
  task automatic do_access(input vec_t v);
    exp_t e;
    e.owner = v.is_data;
    e.rdata = v.exp_rdata;
    e.err   = 1'b0;
    sb_q.push_back(e);
    if (v.is_data) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    mem_rdata = v.mrdata;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("gnt", {62'd0, if_gnt, d_gnt}, v.is_data ? 64'd1 : 64'd2);
    chk("mem_en_acc", {63'd0, mem_en}, 64'd1);
    chk("mem_we", {63'd0, mem_we}, {63'd0, v.is_data & v.we});
    chk("mem_addr", {32'd0, mem_addr}, {32'd0, v.addr});
    if (v.is_data && v.we) chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, v.wdata});
    chk("owner_acc", {63'd0, owner}, {63'd0, v.is_data});
    // Request-side changes during ACC must not reach the memory port.
    if_addr = ~v.addr; d_addr = ~v.addr; d_wdata = ~v.wdata;
    mem_ready = (v.waits == 0);
    for (int i = 1; i <= v.waits; i++) begin
      @(negedge clk);
      chk("wait_mem_en", {63'd0, mem_en}, 64'd1);
      chk("wait_addr", {32'd0, mem_addr}, {32'd0, v.addr});
      chk("wait_we", {63'd0, mem_we}, {63'd0, v.is_data & v.we});
      if (v.is_data && v.we) chk("wait_wdata", {32'd0, mem_wdata}, {32'd0, v.wdata});
      chk("wait_no_pulse", {60'd0, if_gnt, d_gnt, if_done, d_done}, 64'd0);
      mem_ready = (i == v.waits);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    if_req = 1'b0;
    d_req = 1'b0;
    e = sb_q.pop_front();
    chk("done", {62'd0, if_done, d_done}, e.owner ? 64'd1 : 64'd2);
    chk("rdata", {32'd0, rdata}, {32'd0, e.rdata});
    chk("err", {63'd0, err}, {63'd0, e.err});
    chk("mem_en_resp", {63'd0, mem_en}, 64'd0);
    @(negedge clk);
    chk("done_pulse", {62'd0, if_done, d_done}, 64'd0);
  endtask

  initial begin
    int gnts;
    int k;
    logic seen;
    logic exp_o;

    vecs[0] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,          32'h8C01_0004, 0, 32'h8C01_0004};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF,  32'h1234_5678, 2, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0104, 32'h5555_AAAA,  32'hA5A5_0F0F, 1, 32'hA5A5_0F0F};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0044, 32'h0,          32'h0000_0013, 3, 32'h0000_0013};
    vecs[4] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0BAD_F00D,  32'hFFFF_FFFF, 0, 32'h0};

    reset = 1'b0;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
    if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; mem_rdata = 32'h0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_pulses", {60'd0, if_gnt, d_gnt, if_done, d_done}, 64'd0);
    chk("rst_mem", {62'd0, mem_en, mem_we}, 64'd0);
    chk("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
    chk("rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
    chk("rst_rdata_err", {31'd0, rdata, err}, 64'd0);
    chk("rst_owner", {63'd0, owner}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Conflict after reset: data, fetch, data
    exp_owner_q.push_back(1'b1);
    exp_owner_q.push_back(1'b0);
    exp_owner_q.push_back(1'b1);
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    if_addr = 32'h200; d_addr = 32'h300; mem_ready = 1'b1; mem_rdata = 32'h77;
    gnts = 0;
    for (int c = 0; c < 20 && gnts < 3; c++) begin
      @(negedge clk);
      if (if_gnt || d_gnt) begin
        exp_o = exp_owner_q.pop_front();
        chk("conflict_gnt", {62'd0, if_gnt, d_gnt}, exp_o ? 64'd1 : 64'd2);
        chk("conflict_owner", {63'd0, owner}, {63'd0, exp_o});
        chk("conflict_addr", {32'd0, mem_addr}, exp_o ? 64'h300 : 64'h200);
        gnts++;
      end
    end
    chk("conflict_gnt_count", gnts, 64'd3);
    if_req = 1'b0; d_req = 1'b0;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);

    // Vector table of single accesses
    for (int i = 0; i < 5; i++) begin
      do_access(vecs[i]);
    end

    // Watchdog: data read, memory never answers
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h180; mem_ready = 1'b0; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("wd_gnt", {63'd0, d_gnt}, 64'd1);
    seen = 1'b0;
    k = 0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      if (d_done || if_done) begin
        seen = 1'b1;
        k = c;
        chk("wd_done", {62'd0, if_done, d_done}, 64'd1);
        chk("wd_err", {63'd0, err}, 64'd1);
        chk("wd_rdata", {32'd0, rdata}, 64'd0);
        d_req = 1'b0;
      end
    end
    // gnt is cycle 1, so done in cycle TIMEOUT+2 = 17 is 16 edges later
    chk("wd_latency", k, 64'd16);
    @(negedge clk);
    chk("wd_idle", {59'd0, mem_en, if_gnt, d_gnt, if_done, d_done}, 64'd0);
    chk("wd_err_clear", {63'd0, err}, 64'd0);

    // Reset in the middle of an access
    if_req = 1'b1; if_addr = 32'h80; mem_ready = 1'b0;
    @(negedge clk);
    chk("mid_gnt", {63'd0, if_gnt}, 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_mem_en", {63'd0, mem_en}, 64'd0);
    chk("mid_rst_owner", {63'd0, owner}, 64'd0);
    if_req = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (if_done || d_done) seen = 1'b1;
    end
    chk("mid_rst_no_done", {63'd0, seen}, 64'd0);
    reset = 1'b1;
    @(negedge clk);
    do_access(vecs[0]);
    // Both request: last owner is fetch, so data must win
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; if_addr = 32'h500;
    @(negedge clk);
    chk("post_rst_conflict", {62'd0, if_gnt, d_gnt}, 64'd1);
    chk("post_rst_addr", {32'd0, mem_addr}, 64'h400);
    if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
